// File: rtl/alu_exec_unit.sv
// Execution-stage ALU with a registered result and a 32-step radix-2 shift-add multiplier.
// Single-cycle ops retire from IDLE; MUL occupies the unit for 32 cycles and then spends one cycle in DONE.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy,
    output logic            done
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t          state;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [4:0]      cnt;
    logic [XLEN-1:0] acc_next;

    // Single-cycle operations; MUL is handled by the iterative datapath and never reaches here.
    function automatic logic [XLEN-1:0] alu_op(
        input logic [2:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            OP_AND:  alu_op = a & b;
            OP_OR:   alu_op = a | b;
            OP_ADD:  alu_op = a + b;
            OP_SUB:  alu_op = a - b;
            OP_SLL:  alu_op = a << b[4:0];
            OP_SRL:  alu_op = a >> b[4:0];
            OP_SLT:  alu_op = {{(XLEN-1){1'b0}}, (sa < sb)};
            default: alu_op = '0;
        endcase
    endfunction

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign zero     = (result == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (alu_ctrl == OP_MUL) begin
                            mcand  <= src_a;
                            mplier <= src_b;
                            acc    <= '0;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= S_MUL;
                        end else begin
                            result <= alu_op(alu_ctrl, src_a, src_b);
                            done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    // Last step: the final partial sum goes straight to result.
                    if (cnt == 5'd31) begin
                        result <= acc_next;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized scoreboard bench for alu_exec_unit: the driver queues expected results,
// a negedge monitor pops them on every done pulse and tracks the held result value.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [31:0] res;
        logic        is_mul;
    } exp_t;

    exp_t        sb_q[$];
    int          nvec;
    int          nerr;
    int          bcnt;
    logic [31:0] held;
    logic        finish_req;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .alu_ctrl (alu_ctrl),
        .src_a    (src_a),
        .src_b    (src_b),
        .result   (result),
        .zero     (zero),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the operation semantics.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            3'd0: model = a & b;
            3'd1: model = a | b;
            3'd2: model = a + b;
            3'd3: model = a - b;
            3'd4: model = a << b[4:0];
            3'd5: model = a >> b[4:0];
            3'd6: model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin
                p = {32'd0, a} * {32'd0, b};
                model = p[31:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 4))
            0:       rnd_val = 32'd0;
            1:       rnd_val = 32'hFFFF_FFFF;
            2:       rnd_val = 32'h8000_0000;
            default: rnd_val = $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        start    = 1'b1;
        alu_ctrl = op;
        src_a    = a;
        src_b    = b;
        e.res    = model(op, a, b);
        e.is_mul = (op == 3'b111);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Multiply with junk on the inputs during MUL and a stray start during DONE, all of which must be ignored.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
        issue(3'b111, a, b);
        for (int i = 0; i < 32; i++) begin
            src_a    = $urandom;
            src_b    = $urandom;
            alu_ctrl = 3'($urandom_range(0, 7));
            start    = ($urandom_range(0, 1) == 1);
            @(posedge clk);
            #1;
        end
        start    = 1'b1;
        alu_ctrl = 3'b010;
        src_a    = $urandom;
        src_b    = $urandom;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Monitor: all comparisons live here.
    initial begin
        nvec = 0;
        nerr = 0;
        bcnt = 0;
        held = 32'd0;
    end

    always @(negedge clk) begin
        exp_t it;
        if (rst) begin
            held = 32'd0;
            bcnt = 0;
        end else begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_done: got result=%h, required no done pulse", result);
                end else begin
                    it   = sb_q.pop_front();
                    held = it.res;
                    if (it.is_mul) begin
                        nvec++;
                        if (bcnt != 32 || busy !== 1'b0) begin
                            nerr++;
                            $display("FAIL mul_busy: got busy cycles=%0d busy_at_done=%b, required 32 and 0", bcnt, busy);
                        end
                    end
                end
                bcnt = 0;
            end
            nvec++;
            if (result !== held || zero !== (held == 32'd0)) begin
                nerr++;
                $display("FAIL result%s: got result=%h zero=%b, required result=%h zero=%b",
                         done ? "_done" : "_hold", result, zero, held, (held == 32'd0));
            end
            if (busy) begin
                bcnt++;
                nvec++;
                if (sb_q.size() == 0 || !sb_q[0].is_mul) begin
                    nerr++;
                    $display("FAIL busy_unexpected: got busy=1, required busy=0 with no multiply pending");
                end
            end
            if (finish_req) begin
                nvec++;
                if (sb_q.size() != 0) begin
                    nerr++;
                    $display("FAIL pending: got %0d results never delivered, required 0", sb_q.size());
                end
                $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
                $finish;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required bench to finish");
        $fatal(1, "watchdog expired");
    end

    // Driver
    initial begin
        logic [2:0] op;
        finish_req = 1'b0;
        rst        = 1'b1;
        start      = 1'b0;
        alu_ctrl   = 3'b000;
        src_a      = 32'd0;
        src_b      = 32'd0;
        idle(3);

        // Reset wins over a simultaneous start.
        start    = 1'b1;
        alu_ctrl = 3'b010;
        src_a    = 32'd5;
        src_b    = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        idle(2);

        issue(3'b010, 32'hFFFF_FFFF, 32'd1);
        idle(1);
        issue(3'b011, 32'd5, 32'd7);
        issue(3'b110, 32'hFFFF_FFFF, 32'd1);
        issue(3'b100, 32'd1, 32'h24);
        idle(1);
        run_mul(32'h0000_FFFF, 32'h0001_0001);
        issue(3'b010, 32'd10, 32'd20);
        idle(2);

        // Abort a multiply partway through.
        issue(3'b111, 32'h1234, 32'h5678);
        idle(9);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        idle(3);
        issue(3'b010, 32'd2, 32'd3);

        // Back-to-back single-cycle ops.
        issue(3'b010, 32'd100, 32'd1);
        issue(3'b010, 32'd7, 32'd8);
        idle(2);

        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'b111) begin
                run_mul(rnd_val(), rnd_val());
            end else begin
                issue(op, rnd_val(), rnd_val());
                idle($urandom_range(0, 2));
            end
        end

        idle(3);
        finish_req = 1'b1;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock; the sole clock.
REQ-003 The block SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 The block SHALL have port start  input  1  operation request, sampled on the rising clk edge.
REQ-005 The block SHALL have port alu_ctrl  input  3  operation select, using the control FSM's ALUCtrl encoding.
REQ-006 The block SHALL have port src_a  input  XLEN  operand A, driven by the ALUsrcA-selected source.
REQ-007 The block SHALL have port src_b  input  XLEN  operand B, driven by the ALUsrcB-selected source.
REQ-008 The block SHALL have port result  output  XLEN  registered ALUOut value.
REQ-009 The block SHALL have port zero  output  1  high when result == 0, decoded combinationally from the result register.
REQ-010 The block SHALL have port busy  output  1  high while a multiply is in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse marking the cycle in which result is updated.

Function
REQ-012 The alu_ctrl encoding SHALL be:
- 000 AND
- 001 OR
- 010 ADD
- 011 SUB
- 100 SLL by src_b[4:0]
- 101 SRL (logical) by src_b[4:0]
- 110 SLT (signed; result 1 or 0)
- 111 MUL (low XLEN bits of the product)
REQ-013 ADD, SUB and MUL SHALL wrap modulo 2^XLEN; carry and overflow are discarded.
REQ-014 The FSM SHALL have three states: IDLE, MUL and DONE.
REQ-015 In IDLE, start=1 with alu_ctrl!=111 SHALL load result at that edge, stay in IDLE, and pulse done=1 for the next cycle (1-cycle latency).
REQ-016 In IDLE, start=1 with alu_ctrl==111 SHALL, at that edge:
- capture the multiplicand (src_a) and multiplier (src_b);
- clear the accumulator and the 5-bit iteration counter;
- move to MUL with busy=1.
REQ-017 In MUL, each edge SHALL perform one radix-2 shift-add step: accumulator += multiplicand when multiplier LSB=1; multiplicand <<= 1; multiplier >>= 1; counter += 1.
REQ-018 On the edge that completes iteration 32 (counter 31->0 wrap), the block SHALL:
- write the accumulator to result;
- move to DONE;
- drop busy, with done=1 during the DONE cycle.
REQ-019 DONE SHALL return to IDLE unconditionally after one cycle; start sampled in DONE SHALL be ignored.
REQ-020 Multiply latency SHALL be exactly 33 edges from the start edge to done; busy SHALL be high for 32 cycles.
REQ-021 start, alu_ctrl, src_a and src_b SHALL be ignored while busy=1; operand changes during MUL SHALL NOT affect the product.
REQ-022 result SHALL hold its value between operations; zero SHALL track result at all times.
REQ-023 done SHALL never be high in two consecutive cycles unless back-to-back single-cycle starts are issued in IDLE.
REQ-024 A start with alu_ctrl!=111 in the cycle immediately after a done pulse (IDLE) SHALL be accepted normally.

Reset
REQ-025 rst=1 at a rising edge SHALL force:
- state=IDLE;
- result=0, so zero=1;
- busy=0, done=0;
- accumulator, multiplicand, multiplier and counter cleared.
REQ-026 rst SHALL take priority over start in the same cycle.
REQ-027 rst asserted mid-multiply SHALL abort the operation with no done pulse, and no stale value SHALL reach result.

Verification
REQ-028 ADD: start, alu_ctrl=010, src_a=0xFFFFFFFF, src_b=1 -> next cycle result=0, zero=1, done=1, busy=0.
REQ-029 SUB/SLT: 011 with 5,7 -> result=0xFFFFFFFE; 110 with 0xFFFFFFFF,1 -> result=1; 100 with 1,0x24 -> result=0x10.
REQ-030 MUL: 111 with 0x0000FFFF, 0x00010001 -> busy for 32 cycles, done on edge 33, result=0xFFFFFFFF, zero=0.
REQ-031 MUL operand and start changes: alter src_a/src_b and pulse start with 010 during MUL -> product unchanged, only one done pulse.
REQ-032 Reset mid-MUL: rst=1 at iteration 10 of 0x1234*0x5678 -> result=0, zero=1, busy=0, no done; a following ADD 2+3 -> result=5.
REQ-033 Back-to-back: ADD in IDLE on consecutive edges -> done high both cycles, result updated each cycle.
